// File: rtl/multi_dataflow_tile_sequencer_pkg.sv
// Shared types and constants for the multi_dataflow tile sequencer and its
// per-channel address/completion trackers.
package multi_dataflow_seq_package;

  localparam int SEQ_ADDR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_COMPUTE,
    ST_UPDATE,
    ST_FINISHED
  } seq_state_t;

  // Per-channel shadow configuration captured when a job is accepted.
  typedef struct packed {
    logic [SEQ_ADDR_W-1:0] base;
    logic [SEQ_ADDR_W-1:0] stride;
  } seq_chan_cfg_t;

endpackage

// File: rtl/multi_dataflow_tile_sequencer_channel.sv
// One streamer channel: sticky done flag, optional saturating handshake
// counter (sink channels only) and tile base-address accumulator.
module multi_dataflow_seq_channel
  import multi_dataflow_seq_package::*;
#(
  parameter int CNT_W   = 32,
  parameter bit HAS_CNT = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  count_en,
  input  logic                  done_pulse,
  input  logic                  hs,
  input  logic [CNT_W-1:0]      limit,
  input  seq_chan_cfg_t         cfg,
  output logic [SEQ_ADDR_W-1:0] addr,
  output logic                  complete
);

  logic                  done_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_inc;
  logic [CNT_W-1:0]      limit_reg;
  logic [SEQ_ADDR_W-1:0] stride_reg;
  logic [SEQ_ADDR_W-1:0] addr_reg;
  logic                  cnt_ok;

  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
      limit_reg  <= '0;
      stride_reg <= '0;
      addr_reg   <= '0;
    end else begin
      if (load) begin
        addr_reg   <= cfg.base;
        stride_reg <= cfg.stride;
        limit_reg  <= HAS_CNT ? limit : '0;
      end else if (advance) begin
        addr_reg <= addr_reg + stride_reg;
      end
      if (clr) begin
        done_reg <= 1'b0;
        cnt_reg  <= '0;
      end else if (count_en) begin
        if (done_pulse) done_reg <= 1'b1;
        // Saturate at the limit so surplus handshakes cannot skip past it.
        if (HAS_CNT && hs && (cnt_reg != limit_reg)) cnt_reg <= cnt_inc;
      end
    end
  end

  // Pulses arriving this cycle already count toward completion.
  assign cnt_ok = !HAS_CNT || (cnt_reg == limit_reg) ||
                  (count_en && hs && (cnt_inc == limit_reg));
  assign complete = (done_reg || (count_en && done_pulse)) && cnt_ok;
  assign addr     = addr_reg;

endmodule

// File: rtl/multi_dataflow_tile_sequencer.sv
// Job sequencer: loops over nb_iter tiles, pulsing streamer/engine starts,
// waiting for every channel to complete and advancing per-channel addresses.
module multi_dataflow_tile_sequencer
  import multi_dataflow_seq_package::*;
#(
  parameter int N_IN    = 3,
  parameter int N_OUT   = 1,
  parameter int CNT_W   = 32,
  parameter int N_CORES = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clear_i,
  input  logic                                  start_i,
  input  logic [CNT_W-1:0]                      nb_iter_i,
  input  logic [N_OUT-1:0][CNT_W-1:0]           out_cnt_limit_i,
  input  logic [N_IN+N_OUT-1:0][SEQ_ADDR_W-1:0] base_addr_i,
  input  logic [N_IN+N_OUT-1:0][SEQ_ADDR_W-1:0] tile_stride_i,
  output logic [N_IN-1:0]                       src_start_o,
  input  logic [N_IN-1:0]                       src_done_i,
  output logic [N_OUT-1:0]                      sink_start_o,
  input  logic [N_OUT-1:0]                      sink_done_i,
  input  logic [N_OUT-1:0]                      out_hs_i,
  output logic                                  engine_start_o,
  output logic [N_IN+N_OUT-1:0][SEQ_ADDR_W-1:0] addr_o,
  output logic [CNT_W-1:0]                      tile_idx_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [N_CORES-1:0]                    evt_o
);

  localparam int N_CH = N_IN + N_OUT;

  seq_state_t                state_reg, state_next;
  logic [CNT_W-1:0]          nb_iter_reg;
  logic [CNT_W-1:0]          tile_idx_reg;
  logic [CNT_W-1:0]          tile_idx_inc;
  logic                      srst;
  logic                      load;
  logic                      tile_complete;
  logic [N_CH-1:0]           ch_complete;
  seq_chan_cfg_t [N_CH-1:0]  ch_cfg;

  assign srst         = rst_i || clear_i;
  assign load         = (state_reg == ST_IDLE) && start_i;
  assign tile_idx_inc = tile_idx_reg + CNT_W'(1);
  assign tile_complete = &ch_complete;

  always_ff @(posedge clk_i) begin
    if (srst) begin
      state_reg    <= ST_IDLE;
      nb_iter_reg  <= '0;
      tile_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        nb_iter_reg  <= nb_iter_i;
        tile_idx_reg <= '0;
      end else if (state_reg == ST_UPDATE) begin
        tile_idx_reg <= tile_idx_inc;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) state_next = (nb_iter_i == '0) ? ST_FINISHED : ST_START;
      end
      ST_START:    state_next = ST_COMPUTE;
      ST_COMPUTE: begin
        if (tile_complete) state_next = ST_UPDATE;
      end
      ST_UPDATE:   state_next = (tile_idx_inc == nb_iter_reg) ? ST_FINISHED : ST_START;
      ST_FINISHED: state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_src
      assign ch_cfg[gi] = {base_addr_i[gi], tile_stride_i[gi]};
      multi_dataflow_seq_channel #(
        .CNT_W  (CNT_W),
        .HAS_CNT(1'b0)
      ) u_ch (
        .clk_i     (clk_i),
        .rst_i     (srst),
        .clr       (state_reg == ST_START),
        .load      (load),
        .advance   (state_reg == ST_UPDATE),
        .count_en  (state_reg == ST_COMPUTE),
        .done_pulse(src_done_i[gi]),
        .hs        (1'b0),
        .limit     ({CNT_W{1'b0}}),
        .cfg       (ch_cfg[gi]),
        .addr      (addr_o[gi]),
        .complete  (ch_complete[gi])
      );
    end
    for (gi = 0; gi < N_OUT; gi++) begin : g_sink
      assign ch_cfg[N_IN+gi] = {base_addr_i[N_IN+gi], tile_stride_i[N_IN+gi]};
      multi_dataflow_seq_channel #(
        .CNT_W  (CNT_W),
        .HAS_CNT(1'b1)
      ) u_ch (
        .clk_i     (clk_i),
        .rst_i     (srst),
        .clr       (state_reg == ST_START),
        .load      (load),
        .advance   (state_reg == ST_UPDATE),
        .count_en  (state_reg == ST_COMPUTE),
        .done_pulse(sink_done_i[gi]),
        .hs        (out_hs_i[gi]),
        .limit     (out_cnt_limit_i[gi]),
        .cfg       (ch_cfg[N_IN+gi]),
        .addr      (addr_o[N_IN+gi]),
        .complete  (ch_complete[N_IN+gi])
      );
    end
  endgenerate

  assign src_start_o    = {N_IN{state_reg == ST_START}};
  assign sink_start_o   = {N_OUT{state_reg == ST_START}};
  assign engine_start_o = (state_reg == ST_START);
  assign busy_o         = (state_reg != ST_IDLE);
  assign done_o         = (state_reg == ST_FINISHED);
  assign evt_o          = {N_CORES{state_reg == ST_FINISHED}};
  assign tile_idx_o     = tile_idx_reg;

endmodule

// File: tb/tb_multi_dataflow_tile_sequencer.sv
// Directed bench for the tile sequencer: single tile, multi-tile addressing,
// out-of-order completion, empty job, soft clear, wrap-around and immunity.
module tb_multi_dataflow_tile_sequencer;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              clear_i;
  logic              start_i;
  logic [31:0]       nb_iter_i;
  logic [0:0][31:0]  out_cnt_limit_i;
  logic [3:0][31:0]  base_addr_i;
  logic [3:0][31:0]  tile_stride_i;
  logic [2:0]        src_start_o;
  logic [2:0]        src_done_i;
  logic [0:0]        sink_start_o;
  logic [0:0]        sink_done_i;
  logic [0:0]        out_hs_i;
  logic              engine_start_o;
  logic [3:0][31:0]  addr_o;
  logic [31:0]       tile_idx_o;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        evt_o;

  int compared   = 0;
  int mismatched = 0;
  int eng_cnt    = 0;
  int done_cnt   = 0;
  int eng_base;
  int done_base;

  always #5 clk_i = ~clk_i;

  multi_dataflow_tile_sequencer #(
    .N_IN(3), .N_OUT(1), .CNT_W(32), .N_CORES(2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .nb_iter_i      (nb_iter_i),
    .out_cnt_limit_i(out_cnt_limit_i),
    .base_addr_i    (base_addr_i),
    .tile_stride_i  (tile_stride_i),
    .src_start_o    (src_start_o),
    .src_done_i     (src_done_i),
    .sink_start_o   (sink_start_o),
    .sink_done_i    (sink_done_i),
    .out_hs_i       (out_hs_i),
    .engine_start_o (engine_start_o),
    .addr_o         (addr_o),
    .tile_idx_o     (tile_idx_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .evt_o          (evt_o)
  );

  always @(negedge clk_i) begin
    if (engine_start_o) eng_cnt++;
    if (done_o) done_cnt++;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All completion pulses in one cycle; completes a tile when limit <= 1.
  task automatic pulse_all(input logic hs);
    src_done_i  = 3'b111;
    sink_done_i = 1'b1;
    out_hs_i    = hs;
    step();
    src_done_i  = '0;
    sink_done_i = '0;
    out_hs_i    = '0;
  endtask

  task automatic kick();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; nb_iter_i = '0;
    out_cnt_limit_i = '0; base_addr_i = '0; tile_stride_i = '0;
    src_done_i = '0; sink_done_i = '0; out_hs_i = '0;
    step(); step();
    rst_i = 1'b0;

    // Reset state
    check("rst_busy", busy_o, 0);
    check("rst_done_evt", {done_o, evt_o}, 0);
    check("rst_starts", {src_start_o, sink_start_o, engine_start_o}, 0);
    check("rst_addr", addr_o, 0);
    check("rst_tile", tile_idx_o, 0);

    // Single tile, limit 4
    nb_iter_i = 1; out_cnt_limit_i[0] = 4;
    base_addr_i = {32'h400, 32'h300, 32'h200, 32'h100};
    tile_stride_i = {4{32'h10}};
    eng_base = eng_cnt; done_base = done_cnt;
    kick();
    check("t1_start_pulses", {src_start_o, sink_start_o, engine_start_o}, 5'b11111);
    check("t1_addr0", addr_o[0], 32'h100);
    check("t1_addr3", addr_o[3], 32'h400);
    step();
    check("t1_compute_pulses", {src_start_o, sink_start_o, engine_start_o}, 0);
    out_hs_i = 1'b1;
    repeat (4) step();
    out_hs_i = 1'b0;
    pulse_all(1'b0);
    check("t1_update_done", done_o, 0);
    step();
    check("t1_finished", {done_o, evt_o, busy_o}, 4'b1111);
    step();
    check("t1_idle", {busy_o, done_o}, 0);
    check("t1_eng_pulses", eng_cnt - eng_base, 1);
    check("t1_done_pulses", done_cnt - done_base, 1);
    $display("[tb] job single_tile ended");

    // Three tiles with address advance and mid-job config changes
    nb_iter_i = 3; out_cnt_limit_i[0] = 1;
    base_addr_i = {4{32'h1000}}; tile_stride_i = {4{32'h40}};
    eng_base = eng_cnt; done_base = done_cnt;
    kick();
    check("t2_addr_tile0", addr_o[0], 32'h1000);
    check("t2_idx_tile0", tile_idx_o, 0);
    step();
    nb_iter_i = 1; base_addr_i = {4{32'hDEAD0000}};
    kick();
    pulse_all(1'b1);
    step();
    check("t2_addr_tile1", addr_o[0], 32'h1040);
    check("t2_idx_tile1", tile_idx_o, 1);
    step();
    pulse_all(1'b1);
    step();
    check("t2_addr_tile2", addr_o[0], 32'h1080);
    check("t2_idx_tile2", tile_idx_o, 2);
    step();
    pulse_all(1'b1);
    step();
    check("t2_finished", done_o, 1);
    step();
    check("t2_idle", busy_o, 0);
    check("t2_eng_pulses", eng_cnt - eng_base, 3);
    check("t2_done_pulses", done_cnt - done_base, 1);
    $display("[tb] job three_tiles ended");

    // Out-of-order completion with a surplus handshake
    nb_iter_i = 1; out_cnt_limit_i[0] = 4;
    kick();
    step();
    sink_done_i = 1'b1; step(); sink_done_i = 1'b0;
    out_hs_i = 1'b1; repeat (5) step(); out_hs_i = 1'b0;
    step();
    check("t3_wait_src", {done_o, tile_idx_o}, 0);
    src_done_i = 3'b011; step(); src_done_i = '0;
    step(); step();
    check("t3_wait_src2", {done_o, tile_idx_o}, 0);
    check("t3_busy", busy_o, 1);
    src_done_i = 3'b100; step(); src_done_i = '0;
    step();
    check("t3_finished", {done_o, tile_idx_o}, {1'b1, 32'd1});
    step();
    $display("[tb] job out_of_order ended");

    // Empty job
    nb_iter_i = 0;
    eng_base = eng_cnt;
    kick();
    check("t4_finished", {done_o, evt_o, busy_o}, 4'b1111);
    check("t4_no_starts", {src_start_o, sink_start_o, engine_start_o}, 0);
    step();
    check("t4_idle", busy_o, 0);
    check("t4_eng_pulses", eng_cnt - eng_base, 0);
    $display("[tb] job empty ended");

    // Soft clear during tile 1, then restart at a new base
    nb_iter_i = 3; out_cnt_limit_i[0] = 1;
    base_addr_i = {4{32'h1000}}; tile_stride_i = {4{32'h40}};
    done_base = done_cnt;
    kick();
    step();
    pulse_all(1'b1);
    step();
    check("t5_idx_tile1", tile_idx_o, 1);
    step();
    clear_i = 1'b1; step(); clear_i = 1'b0;
    check("t5_clear_state", {busy_o, done_o, evt_o}, 0);
    check("t5_clear_addr", addr_o, 0);
    check("t5_clear_idx", tile_idx_o, 0);
    check("t5_no_done", done_cnt - done_base, 0);
    nb_iter_i = 1; base_addr_i = {4{32'h2000}};
    kick();
    check("t5_restart", {addr_o[0], tile_idx_o}, {32'h2000, 32'd0});
    step();
    pulse_all(1'b1);
    step();
    check("t5_finished", done_o, 1);
    step();
    $display("[tb] job clear_restart ended");

    // Address wrap-around with sink limit 0
    nb_iter_i = 2; out_cnt_limit_i[0] = 0;
    base_addr_i = {4{32'hFFFF_FFC0}}; tile_stride_i = {4{32'h80}};
    kick();
    check("t6_addr_tile0", addr_o[0], 32'hFFFF_FFC0);
    step();
    pulse_all(1'b0);
    step();
    check("t6_addr_tile1", addr_o[0], 32'h40);
    step();
    pulse_all(1'b0);
    step();
    check("t6_finished", done_o, 1);
    step();
    check("t6_idle", busy_o, 0);
    $display("[tb] job wrap ended");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
